// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    // Fault if misaligned, outside the array (unless it hits MMIO), or a store with no lanes.
    function automatic logic dmem_err(input logic [31:0] addr, input logic we,
                                      input logic [3:0] be, input int unsigned depth,
                                      input logic mmio_hit);
        logic w_misalign;
        logic w_oor;
        w_misalign = (addr[1:0] != 2'b00);
        w_oor      = !mmio_hit && ({2'b00, addr[31:2]} >= depth);
        return w_misalign || w_oor || (we && (be == 4'h0));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane-writable word storage; synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < dmem_pkg::WORD_BYTES; b++) begin
                if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states.
// Optional output register at MMIO_ADDR when DMEM_MMIO_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept, w_enter_resp;
    logic        w_c_we, w_c_err, w_mmio_hit, w_arr_we;
    logic [31:0] w_c_addr, w_c_wdata, w_arr_rdata, w_ld_data;
    logic [3:0]  w_c_be;

    // Commit happens on the edge into RESP; with zero wait states that is the accept edge,
    // so the live request fields are used instead of the not-yet-latched copies.
    assign w_c_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_c_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_c_be    = (r_state == IDLE) ? req_be    : r_be;

`ifdef DMEM_MMIO_EN
    logic [31:0] r_mmio;
    assign w_mmio_hit = (w_c_addr == MMIO_ADDR);
    assign w_ld_data  = w_mmio_hit ? r_mmio : w_arr_rdata;
    assign mmio_out   = r_mmio;
`else
    assign w_mmio_hit = 1'b0;
    assign w_ld_data  = w_arr_rdata;
`endif

    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
    assign w_c_err      = dmem_err(w_c_addr, w_c_we, w_c_be, DEPTH_WORDS, w_mmio_hit);
    assign w_arr_we     = w_enter_resp && w_c_we && !w_c_err && !w_mmio_hit;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (w_c_be),
        .i_idx   (w_c_addr[AW+1:2]),
        .i_wdata (w_c_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (r_cnt == 4'd1) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_rdata <= (w_c_we || w_c_err) ? 32'd0 : w_ld_data;
                r_err   <= w_c_err;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mmio <= 32'd0;
        end else if (w_enter_resp && w_c_we && !w_c_err && w_mmio_hit) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (w_c_be[b]) r_mmio[8*b +: 8] <= w_c_wdata[8*b +: 8];
            end
        end
    end
`endif

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a one-wait-state instance and a zero-wait-state instance.
module tb_dmem_responder;

    localparam int          DEPTH  = 1024;
    localparam int          WAITC  = 1;
    localparam int          DEPTH0 = 16;
    localparam logic [31:0] MMIO_A = 32'hFFFF_FFF0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0 = 0, req_we0 = 0;
    logic        rsp_ready0 = 1;
    logic [31:0] req_addr0 = 0, req_wdata0 = 0;
    logic [3:0]  req_be0 = 0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out, mmio_out0;
`endif

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .MMIO_ADDR(MMIO_A)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_MMIO_EN
        , .mmio_out(mmio_out)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0), .MMIO_ADDR(MMIO_A)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0), .rsp_valid(rsp_valid0),
        .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
`ifdef DMEM_MMIO_EN
        , .mmio_out(mmio_out0)
`endif
    );

    typedef struct { logic err; logic [31:0] rdata; } exp_t;
    exp_t        sb[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] mmio_mdl = 32'd0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: decide the expected response and update the model memory.
    task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
        exp_t e;
        logic hit;
        hit = 1'b0;
`ifdef DMEM_MMIO_EN
        hit = (addr == MMIO_A);
`endif
        e.err   = (addr[1:0] != 0) || (!hit && (addr >> 2) >= DEPTH) || (we && be == 0);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        if (hit) mmio_mdl[8*b +: 8] = wdata[8*b +: 8];
                        else     mdl[addr[31:2]][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end else begin
                e.rdata = hit ? mmio_mdl : mdl[addr[31:2]];
            end
        end
        sb.push_back(e);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
        int          n;
        exp_t        e;
        logic [31:0] r0;
        logic        e0;
        push_exp(we, addr, wdata, be);
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        n = 1;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        chk("latency", 32'(n), 32'(WAITC + 1));
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rdata", rsp_rdata, e.rdata);
            chk("err", {31'd0, rsp_err}, {31'd0, e.err});
        end
        if (hold > 0) begin
            r0 = rsp_rdata; e0 = rsp_err;
            // A competing store that must not be taken while the response is pending.
            req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0; req_be = 4'hF;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("hold_rdata", rsp_rdata, r0);
                chk("hold_err", {31'd0, rsp_err}, {31'd0, e0});
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0; req_valid = 0;
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rdata", rsp_rdata, 32'd0);
        chk("post_err", {31'd0, rsp_err}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int          nv;
        logic [31:0] a;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
`ifdef DMEM_MMIO_EN
        chk("rst_mmio", mmio_out, 32'd0);
`endif
        rst = 1;

        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 32'h10, 32'h0, 4'h0, 0);
        txn(1, 32'h10, 32'h000000AA, 4'h1, 0);
        txn(0, 32'h10, 32'h0, 4'hF, 0);
        txn(0, 32'h12, 32'h0, 4'hF, 0);
        txn(1, 32'h0, 32'h11223344, 4'hF, 0);
        txn(1, DEPTH * 4, 32'hFFFFFFFF, 4'hF, 0);
        txn(0, 32'h0, 32'h0, 4'h0, 0);
        txn(0, 32'h10, 32'h0, 4'h0, 5);
        txn(0, 32'h10, 32'h0, 4'h0, 0);
        txn(1, 32'h10, 32'h55555555, 4'h0, 0);
        txn(0, 32'h10, 32'h0, 4'h0, 0);
`ifdef DMEM_MMIO_EN
        txn(1, MMIO_A, 32'h00000005, 4'hF, 0);
        chk("mmio_out", mmio_out, 32'd5);
`endif
        txn(0, MMIO_A, 32'h0, 4'h0, 0);

        for (int w = 0; w < 8; w++) txn(1, 32'(w * 4), $urandom, 4'hF, 0);
        for (int k = 0; k < 16; k++) begin
            a = 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'd1;
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0);
        end

        txn(1, 32'h20, 32'h0BADF00D, 4'hF, 0);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk);
        #2;
        req_valid = 0;
        rst = 0;
        #1;
        chk("midwait_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midwait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midwait_rdata", rsp_rdata, 32'd0);
        chk("midwait_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1;
        txn(0, 32'h20, 32'h0, 4'h0, 0);

        // Zero-wait-state instance with the response channel always ready.
        @(negedge clk);
        req_valid0 = 1; req_we0 = 1; req_addr0 = 32'h4; req_wdata0 = 32'h0000_0011; req_be0 = 4'hF;
        @(negedge clk);
        chk("w0_store_valid", {31'd0, rsp_valid0}, 32'd1);
        chk("w0_store_err", {31'd0, rsp_err0}, 32'd0);
        req_we0 = 0;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid0) begin
                nv++;
                chk("w0_load_rdata", rsp_rdata0, 32'h0000_0011);
            end
        end
        chk("w0_b2b_count", 32'(nv), 32'd6);
        req_we0 = 1; req_be0 = 4'h0; req_wdata0 = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        req_valid0 = 0;
        chk("w0_be0_valid", {31'd0, rsp_valid0}, 32'd1);
        chk("w0_be0_err", {31'd0, rsp_err0}, 32'd1);
        chk("w0_be0_rdata", rsp_rdata0, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
